sram_phase_controller: RTL

Owns the frame-buffer phase sequencing and port-B arbitration of the pixel SRAM (mem_block) in the MAX10_CLK1_50 domain. The frame buffer cycles through five phases: SPI load, armed, dither processing, drain and SPI unload. During processing it grants port B to the dithering engine, with a guaranteed low-rate slot for the switch-driven debug query. Outside processing, the debug query owns port B read-only.

---
 rtl/sram_phase_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_phase_controller.sv
// Frame-buffer phase sequencer and port-B arbiter for the pixel SRAM.
// Engine owns port B during PROCESS, with a forced debug slot after STARVE_LIM grants.
module sram_phase_controller #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int STARVE_LIM = 15
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              load_done,
  input  logic              unload_done,
  input  logic              fn_trigger,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_b,
  output logic              mem_rden_b,
  output logic              mem_wren_b,
  input  logic [DATA_W-1:0] mem_q_b,
  output logic              load_en,
  output logic              read_en,
  output logic [2:0]        phase,
  output logic [7:0]        frame_cnt
);

  localparam int DCW = $clog2(RD_LAT + 1);
  localparam int SCW = $clog2(STARVE_LIM + 1);

  typedef enum logic [2:0] {
    PH_LOAD    = 3'd0,
    PH_ARMED   = 3'd1,
    PH_PROCESS = 3'd2,
    PH_DRAIN   = 3'd3,
    PH_UNLOAD  = 3'd4
  } phase_t;

  phase_t           ph_q, ph_d;
  logic             fn_q;
  logic [DCW-1:0]   drain_cnt;
  logic [SCW-1:0]   starve_cnt;
  logic             force_dbg, eng_rd, dbg_slot;
  logic [RD_LAT:0]  eng_tag, dbg_tag;

  always_comb begin
    ph_d = ph_q;
    if (abort) ph_d = PH_LOAD;
    else begin
      case (ph_q)
        PH_LOAD:    if (load_done) ph_d = PH_ARMED;
        PH_ARMED:   if (fn_trigger && !fn_q) ph_d = PH_PROCESS;
        PH_PROCESS: if (eng_done) ph_d = PH_DRAIN;
        PH_DRAIN:   if (drain_cnt == DCW'(RD_LAT)) ph_d = PH_UNLOAD;
        PH_UNLOAD:  if (unload_done) ph_d = PH_LOAD;
        default:    ph_d = PH_LOAD;
      endcase
    end
  end

  // abort also withholds the grant so the engine never sees a dropped access as accepted
  assign force_dbg = (starve_cnt == SCW'(STARVE_LIM));
  assign eng_gnt   = (ph_q == PH_PROCESS) && eng_req && !force_dbg && !abort;
  assign eng_rd    = eng_gnt && !eng_we;
  assign dbg_slot  = !eng_gnt && !abort;

  assign phase      = ph_q;
  assign eng_rvalid = eng_tag[RD_LAT];

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst_n) begin
      ph_q       <= PH_LOAD;
      fn_q       <= 1'b0;
      eng_start  <= 1'b0;
      load_en    <= 1'b1;
      read_en    <= 1'b0;
      drain_cnt  <= '0;
      starve_cnt <= '0;
      frame_cnt  <= '0;
      mem_addr_b <= '0;
      mem_data_b <= '0;
      mem_rden_b <= 1'b0;
      mem_wren_b <= 1'b0;
      eng_tag    <= '0;
      dbg_tag    <= '0;
      eng_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      ph_q       <= ph_d;
      fn_q       <= fn_trigger;
      eng_start  <= (ph_q == PH_ARMED) && (ph_d == PH_PROCESS);
      load_en    <= (ph_d == PH_LOAD);
      read_en    <= (ph_d == PH_UNLOAD);
      drain_cnt  <= (ph_q == PH_DRAIN && ph_d == PH_DRAIN) ? drain_cnt + DCW'(1) : '0;
      starve_cnt <= eng_gnt ? starve_cnt + SCW'(1) : '0;
      if (!abort && ph_q == PH_UNLOAD && unload_done) frame_cnt <= frame_cnt + 8'd1;

      if (abort) begin
        mem_rden_b <= 1'b0;
        mem_wren_b <= 1'b0;
      end else if (eng_gnt) begin
        mem_addr_b <= eng_addr;
        mem_data_b <= eng_wdata;
        mem_wren_b <= eng_we;
        mem_rden_b <= !eng_we;
      end else begin
        mem_addr_b <= dbg_addr;
        mem_rden_b <= 1'b1;
        mem_wren_b <= 1'b0;
      end

      // last tag stage doubles as eng_rvalid; data is captured one stage earlier
      if (abort) begin
        eng_tag <= '0;
        dbg_tag <= '0;
      end else begin
        eng_tag <= {eng_tag[RD_LAT-1:0], eng_rd};
        dbg_tag <= {dbg_tag[RD_LAT-1:0], dbg_slot};
        if (eng_tag[RD_LAT-1]) eng_rdata <= mem_q_b;
        if (dbg_tag[RD_LAT-1]) dbg_rdata <= mem_q_b;
      end
    end
  end

endmodule
